// File: rtl/rename_map.sv
// -----------------------------------------------------------------------------
// rename_map
//
// Two-wide register rename stage placed directly in front of the physical
// register freelist. Architectural sources and destinations (x0..x31) are
// translated to physical tags through a speculative RAT. New destination tags
// are popped from the freelist read ports. A committed RAT is kept for flush
// recovery, and superseded tags are pushed back to the freelist at retire.
// The renamed group leaves through one registered stage with valid/ready on
// both sides.
//
// Ports
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_vld / o_ready            incoming rename group handshake
//   i_slot_vld, i_rd_wr        per-slot presence and rd-write flags (slot0 older)
//   i_rs1_n, i_rs2_n, i_rd_n   architectural indices per slot
//   o_fl_rd0/1, i_fl_data0/1   freelist pops and head tags
//   i_fl_empty0/1              fewer than one / fewer than two tags available
//   o_fl_wr_en0/1, _data0/1    freed tags pushed back to the freelist
//   i_cmt_*                    retire port: rd, new tag, superseded tag
//   i_flush                    restore speculative RAT from committed RAT
//   o_vld / i_ready            outgoing renamed group handshake
//   o_slot_vld, o_prs*/prd*/oprd*  renamed group contents
// -----------------------------------------------------------------------------
module rename_map #(
    parameter int ARCH_W = 5,
    parameter int PHYS_W = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_vld,
    output logic              o_ready,
    input  logic [1:0]        i_slot_vld,
    input  logic [ARCH_W-1:0] i_rs1_0,
    input  logic [ARCH_W-1:0] i_rs2_0,
    input  logic [ARCH_W-1:0] i_rd_0,
    input  logic [ARCH_W-1:0] i_rs1_1,
    input  logic [ARCH_W-1:0] i_rs2_1,
    input  logic [ARCH_W-1:0] i_rd_1,
    input  logic [1:0]        i_rd_wr,
    output logic              o_fl_rd0,
    output logic              o_fl_rd1,
    input  logic [PHYS_W-1:0] i_fl_data0,
    input  logic [PHYS_W-1:0] i_fl_data1,
    input  logic              i_fl_empty0,
    input  logic              i_fl_empty1,
    output logic              o_fl_wr_en0,
    output logic              o_fl_wr_en1,
    output logic [PHYS_W-1:0] o_fl_wr_data0,
    output logic [PHYS_W-1:0] o_fl_wr_data1,
    input  logic [1:0]        i_cmt_vld,
    input  logic [ARCH_W-1:0] i_cmt_rd_0,
    input  logic [ARCH_W-1:0] i_cmt_rd_1,
    input  logic [PHYS_W-1:0] i_cmt_prd_0,
    input  logic [PHYS_W-1:0] i_cmt_prd_1,
    input  logic [PHYS_W-1:0] i_cmt_oprd_0,
    input  logic [PHYS_W-1:0] i_cmt_oprd_1,
    input  logic              i_flush,
    output logic              o_vld,
    input  logic              i_ready,
    output logic [1:0]        o_slot_vld,
    output logic [PHYS_W-1:0] o_prs1_0,
    output logic [PHYS_W-1:0] o_prs2_0,
    output logic [PHYS_W-1:0] o_prd_0,
    output logic [PHYS_W-1:0] o_oprd_0,
    output logic [PHYS_W-1:0] o_prs1_1,
    output logic [PHYS_W-1:0] o_prs2_1,
    output logic [PHYS_W-1:0] o_prd_1,
    output logic [PHYS_W-1:0] o_oprd_1
);

    localparam int NREG = 1 << ARCH_W;
    typedef logic [PHYS_W-1:0] tag_t;

    tag_t specRat_q [NREG];
    tag_t specRat_d [NREG];
    tag_t cmtRat_q  [NREG];
    tag_t cmtRat_d  [NREG];

    logic       vld_q;
    logic [1:0] slotVld_q, slotVld_d;
    tag_t       prs1_0_q, prs2_0_q, prd_0_q, oprd_0_q;
    tag_t       prs1_1_q, prs2_1_q, prd_1_q, oprd_1_q;
    tag_t       prs1_0_d, prs2_0_d, prd_0_d, oprd_0_d;
    tag_t       prs1_1_d, prs2_1_d, prd_1_d, oprd_1_d;

    logic       flWrEn0_q, flWrEn1_q;
    tag_t       flWrData0_q, flWrData1_q;

    logic       need0, need1, tagsOk, fire;
    logic [1:0] needCnt;
    tag_t       newTag0, newTag1;

    // x0 is hardwired to tag 0, so writes to it never consume a tag.
    assign need0   = i_slot_vld[0] & i_rd_wr[0] & (i_rd_0 != '0);
    assign need1   = i_slot_vld[1] & i_rd_wr[1] & (i_rd_1 != '0);
    assign needCnt = {1'b0, need0} + {1'b0, need1};

    assign tagsOk  = (needCnt == 2'd0)
                   | ((needCnt == 2'd1) & !i_fl_empty0)
                   | ((needCnt == 2'd2) & !i_fl_empty1);
    assign o_ready = !i_rst & !i_flush & (!vld_q | i_ready) & tagsOk;
    assign fire    = i_vld & o_ready;

    // A single allocation always uses the head tag, whichever slot needs it.
    assign o_fl_rd0 = fire & (need0 | need1);
    assign o_fl_rd1 = fire & need0 & need1;
    assign newTag0  = i_fl_data0;
    assign newTag1  = need0 ? i_fl_data1 : i_fl_data0;

    // Rename lookup. Slot1 sees slot0's fresh tag when it reads or overwrites
    // the register slot0 just allocated.
    always_comb begin
        slotVld_d = i_slot_vld;
        prs1_0_d  = '0;
        prs2_0_d  = '0;
        prd_0_d   = '0;
        oprd_0_d  = '0;
        prs1_1_d  = '0;
        prs2_1_d  = '0;
        prd_1_d   = '0;
        oprd_1_d  = '0;
        if (i_slot_vld[0]) begin
            prs1_0_d = specRat_q[i_rs1_0];
            prs2_0_d = specRat_q[i_rs2_0];
        end
        if (need0) begin
            prd_0_d  = newTag0;
            oprd_0_d = specRat_q[i_rd_0];
        end
        if (i_slot_vld[1]) begin
            prs1_1_d = (need0 && (i_rs1_1 == i_rd_0)) ? newTag0 : specRat_q[i_rs1_1];
            prs2_1_d = (need0 && (i_rs2_1 == i_rd_0)) ? newTag0 : specRat_q[i_rs2_1];
        end
        if (need1) begin
            prd_1_d  = newTag1;
            oprd_1_d = (need0 && (i_rd_1 == i_rd_0)) ? newTag0 : specRat_q[i_rd_1];
        end
    end

    // Committed RAT next state; slot1 is younger so its write lands last.
    always_comb begin
        cmtRat_d = cmtRat_q;
        if (i_cmt_vld[0] && (i_cmt_rd_0 != '0)) cmtRat_d[i_cmt_rd_0] = i_cmt_prd_0;
        if (i_cmt_vld[1] && (i_cmt_rd_1 != '0)) cmtRat_d[i_cmt_rd_1] = i_cmt_prd_1;
    end

    // Speculative RAT next state. Flush copies the committed view including
    // this cycle's retirements; otherwise a fired group writes its new tags.
    always_comb begin
        specRat_d = specRat_q;
        if (i_flush) begin
            specRat_d = cmtRat_d;
        end else if (fire) begin
            if (need0) specRat_d[i_rd_0] = newTag0;
            if (need1) specRat_d[i_rd_1] = newTag1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int r = 0; r < NREG; r++) begin
                specRat_q[r] <= tag_t'(r);
                cmtRat_q[r]  <= tag_t'(r);
            end
        end else begin
            specRat_q <= specRat_d;
            cmtRat_q  <= cmtRat_d;
        end
    end

    // Output pipeline register: flush kills the held group, a fire loads a new
    // one, and a downstream accept with nothing new behind it empties it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_q     <= 1'b0;
            slotVld_q <= '0;
            prs1_0_q  <= '0;
            prs2_0_q  <= '0;
            prd_0_q   <= '0;
            oprd_0_q  <= '0;
            prs1_1_q  <= '0;
            prs2_1_q  <= '0;
            prd_1_q   <= '0;
            oprd_1_q  <= '0;
        end else if (i_flush) begin
            vld_q     <= 1'b0;
            slotVld_q <= '0;
        end else if (fire) begin
            vld_q     <= 1'b1;
            slotVld_q <= slotVld_d;
            prs1_0_q  <= prs1_0_d;
            prs2_0_q  <= prs2_0_d;
            prd_0_q   <= prd_0_d;
            oprd_0_q  <= oprd_0_d;
            prs1_1_q  <= prs1_1_d;
            prs2_1_q  <= prs2_1_d;
            prd_1_q   <= prd_1_d;
            oprd_1_q  <= oprd_1_d;
        end else if (i_ready) begin
            vld_q     <= 1'b0;
            slotVld_q <= '0;
        end
    end

    // Superseded tags go back to the freelist one cycle after retire; x0
    // never owned a real tag so it is never pushed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            flWrEn0_q   <= 1'b0;
            flWrEn1_q   <= 1'b0;
            flWrData0_q <= '0;
            flWrData1_q <= '0;
        end else begin
            flWrEn0_q   <= i_cmt_vld[0] & (i_cmt_rd_0 != '0);
            flWrEn1_q   <= i_cmt_vld[1] & (i_cmt_rd_1 != '0);
            flWrData0_q <= (i_cmt_vld[0] && (i_cmt_rd_0 != '0)) ? i_cmt_oprd_0 : '0;
            flWrData1_q <= (i_cmt_vld[1] && (i_cmt_rd_1 != '0)) ? i_cmt_oprd_1 : '0;
        end
    end

    assign o_vld         = vld_q;
    assign o_slot_vld    = slotVld_q;
    assign o_prs1_0      = prs1_0_q;
    assign o_prs2_0      = prs2_0_q;
    assign o_prd_0       = prd_0_q;
    assign o_oprd_0      = oprd_0_q;
    assign o_prs1_1      = prs1_1_q;
    assign o_prs2_1      = prs2_1_q;
    assign o_prd_1       = prd_1_q;
    assign o_oprd_1      = oprd_1_q;
    assign o_fl_wr_en0   = flWrEn0_q;
    assign o_fl_wr_en1   = flWrEn1_q;
    assign o_fl_wr_data0 = flWrData0_q;
    assign o_fl_wr_data1 = flWrData1_q;

endmodule

// File: tb/tb_rename_map.sv
// -----------------------------------------------------------------------------
// tb_rename_map
//
// Self-checking bench for rename_map. A table of rename groups with their
// expected handshake behaviour and renamed tags is applied cycle by cycle;
// expected output groups are queued when a group is expected to fire and
// compared when the DUT presents them. Hand-written sequences cover flush
// recovery and the retire/free path.
// -----------------------------------------------------------------------------
module tb_rename_map;

    typedef struct packed {
        logic [1:0] sv;
        logic [5:0] a0, b0, d0, o0;
        logic [5:0] a1, b1, d1, o1;
    } out_t;

    typedef struct packed {
        logic       vld;
        logic [1:0] sv;
        logic [1:0] wr;
        logic [4:0] a0, b0, d0, a1, b1, d1;
        logic [5:0] f0, f1;
        logic       e0, e1, rdy;
        logic       xReady, xRd0, xRd1;
        out_t       exp;
    } vec_t;

    localparam int NVEC = 13;

    logic       clk;
    logic       i_rst, i_vld, o_ready;
    logic [1:0] i_slot_vld, i_rd_wr;
    logic [4:0] i_rs1_0, i_rs2_0, i_rd_0, i_rs1_1, i_rs2_1, i_rd_1;
    logic       o_fl_rd0, o_fl_rd1;
    logic [5:0] i_fl_data0, i_fl_data1;
    logic       i_fl_empty0, i_fl_empty1;
    logic       o_fl_wr_en0, o_fl_wr_en1;
    logic [5:0] o_fl_wr_data0, o_fl_wr_data1;
    logic [1:0] i_cmt_vld;
    logic [4:0] i_cmt_rd_0, i_cmt_rd_1;
    logic [5:0] i_cmt_prd_0, i_cmt_prd_1, i_cmt_oprd_0, i_cmt_oprd_1;
    logic       i_flush, o_vld, i_ready;
    logic [1:0] o_slot_vld;
    logic [5:0] o_prs1_0, o_prs2_0, o_prd_0, o_oprd_0;
    logic [5:0] o_prs1_1, o_prs2_1, o_prd_1, o_oprd_1;

    int   checkCount = 0;
    int   passCount  = 0;
    out_t expQ[$];
    vec_t vecs[NVEC];

    rename_map #(.ARCH_W(5), .PHYS_W(6)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_vld(i_vld), .o_ready(o_ready),
        .i_slot_vld(i_slot_vld),
        .i_rs1_0(i_rs1_0), .i_rs2_0(i_rs2_0), .i_rd_0(i_rd_0),
        .i_rs1_1(i_rs1_1), .i_rs2_1(i_rs2_1), .i_rd_1(i_rd_1),
        .i_rd_wr(i_rd_wr),
        .o_fl_rd0(o_fl_rd0), .o_fl_rd1(o_fl_rd1),
        .i_fl_data0(i_fl_data0), .i_fl_data1(i_fl_data1),
        .i_fl_empty0(i_fl_empty0), .i_fl_empty1(i_fl_empty1),
        .o_fl_wr_en0(o_fl_wr_en0), .o_fl_wr_en1(o_fl_wr_en1),
        .o_fl_wr_data0(o_fl_wr_data0), .o_fl_wr_data1(o_fl_wr_data1),
        .i_cmt_vld(i_cmt_vld),
        .i_cmt_rd_0(i_cmt_rd_0), .i_cmt_rd_1(i_cmt_rd_1),
        .i_cmt_prd_0(i_cmt_prd_0), .i_cmt_prd_1(i_cmt_prd_1),
        .i_cmt_oprd_0(i_cmt_oprd_0), .i_cmt_oprd_1(i_cmt_oprd_1),
        .i_flush(i_flush), .o_vld(o_vld), .i_ready(i_ready),
        .o_slot_vld(o_slot_vld),
        .o_prs1_0(o_prs1_0), .o_prs2_0(o_prs2_0), .o_prd_0(o_prd_0), .o_oprd_0(o_oprd_0),
        .o_prs1_1(o_prs1_1), .o_prs2_1(o_prs2_1), .o_prd_1(o_prd_1), .o_oprd_1(o_oprd_1)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports a FAIL line on disagreement.
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic out_t mkOut(input logic [1:0] sv,
                                   input logic [5:0] a0, b0, d0, o0, a1, b1, d1, o1);
        out_t o;
        o.sv = sv; o.a0 = a0; o.b0 = b0; o.d0 = d0; o.o0 = o0;
        o.a1 = a1; o.b1 = b1; o.d1 = d1; o.o1 = o1;
        return o;
    endfunction

    function automatic vec_t mkVec(input logic vld, input logic [1:0] sv, input logic [1:0] wr,
                                   input logic [4:0] a0, b0, d0, a1, b1, d1,
                                   input logic [5:0] f0, f1, input logic e0, e1, rdy,
                                   input logic xReady, xRd0, xRd1, input out_t exp);
        vec_t v;
        v.vld = vld; v.sv = sv; v.wr = wr;
        v.a0 = a0; v.b0 = b0; v.d0 = d0; v.a1 = a1; v.b1 = b1; v.d1 = d1;
        v.f0 = f0; v.f1 = f1; v.e0 = e0; v.e1 = e1; v.rdy = rdy;
        v.xReady = xReady; v.xRd0 = xRd0; v.xRd1 = xRd1; v.exp = exp;
        return v;
    endfunction

    // Drives one rename group onto the input side; commit and flush stay idle.
    task automatic applyStimulus(input vec_t v);
        i_vld       = v.vld;
        i_slot_vld  = v.sv;
        i_rd_wr     = v.wr;
        i_rs1_0     = v.a0; i_rs2_0 = v.b0; i_rd_0 = v.d0;
        i_rs1_1     = v.a1; i_rs2_1 = v.b1; i_rd_1 = v.d1;
        i_fl_data0  = v.f0; i_fl_data1 = v.f1;
        i_fl_empty0 = v.e0; i_fl_empty1 = v.e1;
        i_ready     = v.rdy;
        i_flush     = 1'b0;
        i_cmt_vld   = 2'b00;
    endtask

    // Compares the presented output group against the scoreboard head and
    // retires the head when downstream accepts it.
    task automatic checkOutput();
        out_t e;
        chk("o_vld vs scoreboard", o_vld, expQ.size() != 0);
        if (o_vld && expQ.size() != 0) begin
            e = expQ[0];
            chk("o_slot_vld", o_slot_vld, e.sv);
            chk("o_prs1_0", o_prs1_0, e.a0);
            chk("o_prs2_0", o_prs2_0, e.b0);
            chk("o_prd_0", o_prd_0, e.d0);
            chk("o_oprd_0", o_oprd_0, e.o0);
            chk("o_prs1_1", o_prs1_1, e.a1);
            chk("o_prs2_1", o_prs2_1, e.b1);
            chk("o_prd_1", o_prd_1, e.d1);
            chk("o_oprd_1", o_oprd_1, e.o1);
            if (i_ready) void'(expQ.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        applyStimulus(mkVec(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                            1, 0, 0, mkOut(2'b00, 0, 0, 0, 0, 0, 0, 0, 0)));
        i_cmt_rd_0 = '0; i_cmt_rd_1 = '0;
        i_cmt_prd_0 = '0; i_cmt_prd_1 = '0;
        i_cmt_oprd_0 = '0; i_cmt_oprd_1 = '0;
    endtask

    initial begin
        // Expected tags follow from identity RATs after reset and the
        // allocations made by earlier rows.
        vecs[0]  = mkVec(1, 2'b11, 2'b11,  2, 3, 1,  1, 1, 4, 32, 33, 0, 0, 1, 1, 1, 1,
                         mkOut(2'b11,  2,  3, 32,  1, 32, 32, 33,  4));
        vecs[1]  = mkVec(1, 2'b11, 2'b11,  1, 4, 5,  5, 0, 5, 40, 41, 0, 0, 1, 1, 1, 1,
                         mkOut(2'b11, 32, 33, 40,  5, 40,  0, 41, 40));
        vecs[2]  = mkVec(1, 2'b01, 2'b01,  5, 1, 6,  0, 0, 0, 42, 43, 0, 0, 1, 1, 1, 0,
                         mkOut(2'b01, 41, 32, 42,  6,  0,  0,  0,  0));
        vecs[3]  = mkVec(1, 2'b11, 2'b11,  1, 1, 7,  1, 1, 8, 44, 45, 0, 1, 1, 0, 0, 0,
                         mkOut(2'b00,  0,  0,  0,  0,  0,  0,  0,  0));
        vecs[4]  = mkVec(1, 2'b11, 2'b10,  7, 8, 9,  6, 5, 8, 44, 45, 0, 1, 1, 1, 1, 0,
                         mkOut(2'b11,  7,  8,  0,  0, 42, 41, 44,  8));
        vecs[5]  = mkVec(1, 2'b11, 2'b11,  8, 0, 0,  0, 8, 0, 60, 61, 1, 1, 1, 1, 0, 0,
                         mkOut(2'b11, 44,  0,  0,  0,  0, 44,  0,  0));
        vecs[6]  = mkVec(0, 2'b00, 2'b00,  0, 0, 0,  0, 0, 0,  0,  0, 0, 0, 1, 1, 0, 0,
                         mkOut(2'b00,  0,  0,  0,  0,  0,  0,  0,  0));
        vecs[7]  = mkVec(1, 2'b01, 2'b01,  8, 6, 10, 0, 0, 0, 46, 47, 0, 0, 1, 1, 1, 0,
                         mkOut(2'b01, 44, 42, 46, 10,  0,  0,  0,  0));
        vecs[8]  = mkVec(1, 2'b01, 2'b01, 10, 0, 11, 0, 0, 0, 47, 48, 0, 0, 0, 0, 0, 0,
                         mkOut(2'b00,  0,  0,  0,  0,  0,  0,  0,  0));
        vecs[9]  = vecs[8];
        vecs[10] = vecs[8];
        vecs[11] = mkVec(1, 2'b01, 2'b01, 10, 0, 11, 0, 0, 0, 47, 48, 0, 0, 1, 1, 1, 0,
                         mkOut(2'b01, 46,  0, 47, 11,  0,  0,  0,  0));
        vecs[12] = vecs[6];

        // Reset: hold a tag-needing group at the input to show nothing fires.
        setIdle();
        i_rst = 1'b1;
        applyStimulus(vecs[0]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset o_ready", o_ready, 0);
        chk("reset o_fl_rd0", o_fl_rd0, 0);
        tick();
        setIdle();
        i_rst = 1'b0;
        chk("reset o_vld", o_vld, 0);
        chk("reset o_slot_vld", o_slot_vld, 0);
        chk("reset o_prd_0", o_prd_0, 0);
        chk("reset o_fl_wr_en0", o_fl_wr_en0, 0);

        // Table-driven rename groups through the scoreboard.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput();
            chk($sformatf("v%0d o_ready", i), o_ready, vecs[i].xReady);
            chk($sformatf("v%0d o_fl_rd0", i), o_fl_rd0, vecs[i].xRd0);
            chk($sformatf("v%0d o_fl_rd1", i), o_fl_rd1, vecs[i].xRd1);
            if (vecs[i].vld && vecs[i].xReady) expQ.push_back(vecs[i].exp);
            tick();
        end
        for (int n = 0; n < 4 && expQ.size() != 0; n++) begin
            setIdle();
            @(negedge clk);
            checkOutput();
            tick();
        end
        chk("scoreboard drained", expQ.size(), 0);

        // Flush mid-stream: x3 renamed to 50 but never committed.
        setIdle();
        applyStimulus(mkVec(1, 2'b01, 2'b01, 0, 0, 3, 0, 0, 0, 50, 51, 0, 0, 1, 1, 1, 0,
                            mkOut(2'b00, 0, 0, 0, 0, 0, 0, 0, 0)));
        @(negedge clk);
        chk("flush-pre o_ready", o_ready, 1);
        chk("flush-pre o_fl_rd0", o_fl_rd0, 1);
        tick();
        chk("flush-pre o_vld", o_vld, 1);
        chk("flush-pre o_prd_0", o_prd_0, 50);
        chk("flush-pre o_oprd_0", o_oprd_0, 3);
        i_vld = 1'b0; i_ready = 1'b0; i_flush = 1'b1;
        @(negedge clk);
        chk("flush o_ready", o_ready, 0);
        tick();
        chk("flush o_vld", o_vld, 0);
        applyStimulus(mkVec(1, 2'b01, 2'b00, 3, 11, 0, 0, 0, 0, 52, 53, 0, 0, 1, 1, 0, 0,
                            mkOut(2'b00, 0, 0, 0, 0, 0, 0, 0, 0)));
        @(negedge clk);
        chk("post-flush o_ready", o_ready, 1);
        tick();
        chk("post-flush o_vld", o_vld, 1);
        chk("post-flush prs1_0 x3", o_prs1_0, 3);
        chk("post-flush prs2_0 x11", o_prs2_0, 11);
        setIdle();
        tick();

        // Retire x7 (45 replaces 7) alongside a retire of x0 that must not free.
        i_cmt_vld = 2'b11;
        i_cmt_rd_0 = 7;  i_cmt_prd_0 = 45; i_cmt_oprd_0 = 7;
        i_cmt_rd_1 = 0;  i_cmt_prd_1 = 0;  i_cmt_oprd_1 = 9;
        @(negedge clk);
        chk("commit same-cycle wr_en0", o_fl_wr_en0, 0);
        tick();
        chk("commit wr_en0", o_fl_wr_en0, 1);
        chk("commit wr_data0", o_fl_wr_data0, 7);
        chk("commit x0 wr_en1", o_fl_wr_en1, 0);

        // Flush in the same cycle as retiring x12 -> 55.
        i_cmt_vld = 2'b01;
        i_cmt_rd_0 = 12; i_cmt_prd_0 = 55; i_cmt_oprd_0 = 12;
        i_flush = 1'b1;
        @(negedge clk);
        chk("flush+commit o_ready", o_ready, 0);
        tick();
        chk("flush+commit wr_en0", o_fl_wr_en0, 1);
        chk("flush+commit wr_data0", o_fl_wr_data0, 12);
        chk("flush+commit o_vld", o_vld, 0);

        applyStimulus(mkVec(1, 2'b11, 2'b00, 7, 12, 0, 8, 5, 0, 0, 0, 0, 0, 1, 1, 0, 0,
                            mkOut(2'b00, 0, 0, 0, 0, 0, 0, 0, 0)));
        @(negedge clk);
        chk("committed read o_ready", o_ready, 1);
        chk("committed read o_fl_rd0", o_fl_rd0, 0);
        tick();
        chk("idle wr_en0", o_fl_wr_en0, 0);
        chk("committed read o_vld", o_vld, 1);
        chk("committed prs1_0 x7", o_prs1_0, 45);
        chk("committed prs2_0 x12", o_prs2_0, 55);
        chk("committed prs1_1 x8", o_prs1_1, 8);
        chk("committed prs2_1 x5", o_prs2_1, 5);
        chk("no-write o_prd_0", o_prd_0, 0);
        chk("no-write o_oprd_1", o_oprd_1, 0);
        setIdle();
        tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
